// File: rtl/weight_word_gen_if.sv
// weight_word_gen_if: start/weight request plus the valid/ready word stream of the weight word generator.
interface weight_word_gen_if #(
   parameter int WIDTH = 32,
   parameter int KW = $clog2(WIDTH + 1)
);
   logic start;
   logic [KW-1:0] weight;
   logic out_valid;
   logic out_ready;
   logic [WIDTH-1:0] out_word;
   logic out_last;
   logic [31:0] out_idx;
   logic busy;
   logic done;
   logic err;
   modport master(input start, weight, out_ready, output out_valid, out_word, out_last, out_idx, busy, done, err);
   modport slave(output start, weight, out_ready, input out_valid, out_word, out_last, out_idx, busy, done, err);
endinterface

// File: rtl/weight_word_gen.sv
// weight_word_gen: streams every WIDTH-bit word of Hamming weight k in ascending order.
module weight_word_gen #(
   parameter int WIDTH = 32,
   parameter int KW = $clog2(WIDTH + 1)
) (
   input logic clk,
   input logic rst_n,
   weight_word_gen_if.master b
);
   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
   state_t state, state_nx;
   logic [KW-1:0] kr;
   logic [WIDTH-1:0] nxt, last;
   logic [WIDTH:0] x, c, r;
   logic [KW:0] tz;
   logic go, bad, fire;
   function automatic logic [WIDTH-1:0] ones(input logic [KW-1:0] k);
      logic [WIDTH:0] m;
      m = ((WIDTH + 1)'(1) << k) - (WIDTH + 1)'(1);
      return m[WIDTH-1:0];
   endfunction
   // Gosper's successor: smallest larger word with the same popcount
   always_comb begin
      x = {1'b0, b.out_word};
      c = x & (-x);
      r = x + c;
      tz = '0;
      for (int i = WIDTH - 1; i >= 0; i--) if (x[i]) tz = (KW + 1)'(i);
      nxt = WIDTH'(r | ((r ^ x) >> (tz + (KW + 1)'(2))));
   end
   assign bad = 32'(b.weight) > WIDTH;
   assign go = (state == IDLE) && b.start;
   assign fire = b.out_valid && b.out_ready;
   assign last = ones(kr) << (KW'(WIDTH) - kr);
   assign b.out_valid = state == EMIT;
   assign b.busy = state != IDLE;
   assign b.done = state == DONE;
   assign b.out_last = b.out_valid && (b.out_word == last);
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (go && !bad ? EMIT : IDLE) :
                 state == EMIT ? (fire && b.out_last ? DONE : EMIT) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         kr <= '0;
         b.out_word <= '0;
         b.out_idx <= '0;
         b.err <= 1'b0;
      end else begin
         state <= state_nx;
         b.err <= go && bad;
         if (go && !bad) begin
            kr <= b.weight;
            b.out_word <= ones(b.weight);
            b.out_idx <= '0;
         end else if (fire && !b.out_last) begin
            b.out_word <= nxt;
            b.out_idx <= b.out_idx + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_weight_word_gen.sv
// tb_weight_word_gen: randomized-ready checks of three generator widths against a k-subset enumeration model.
module tb_weight_word_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic start_a[3];
   logic [5:0] weight_a[3];
   logic rdy_a[3];
   logic valid_a[3], last_a[3], busy_a[3], done_a[3], err_a[3];
   logic [31:0] word_a[3], idx_a[3];
   weight_word_gen_if #(.WIDTH(4)) i4();
   weight_word_gen_if #(.WIDTH(8)) i8();
   weight_word_gen_if #(.WIDTH(32)) i32();
   weight_word_gen #(.WIDTH(4)) u4(.clk(clk), .rst_n(rst_n), .b(i4));
   weight_word_gen #(.WIDTH(8)) u8(.clk(clk), .rst_n(rst_n), .b(i8));
   weight_word_gen #(.WIDTH(32)) u32(.clk(clk), .rst_n(rst_n), .b(i32));
   always #5 clk = ~clk;
   assign i4.start = start_a[0];
   assign i8.start = start_a[1];
   assign i32.start = start_a[2];
   assign i4.weight = weight_a[0][2:0];
   assign i8.weight = weight_a[1][3:0];
   assign i32.weight = weight_a[2];
   assign i4.out_ready = rdy_a[0];
   assign i8.out_ready = rdy_a[1];
   assign i32.out_ready = rdy_a[2];
   assign valid_a[0] = i4.out_valid;
   assign valid_a[1] = i8.out_valid;
   assign valid_a[2] = i32.out_valid;
   assign last_a[0] = i4.out_last;
   assign last_a[1] = i8.out_last;
   assign last_a[2] = i32.out_last;
   assign busy_a[0] = i4.busy;
   assign busy_a[1] = i8.busy;
   assign busy_a[2] = i32.busy;
   assign done_a[0] = i4.done;
   assign done_a[1] = i8.done;
   assign done_a[2] = i32.done;
   assign err_a[0] = i4.err;
   assign err_a[1] = i8.err;
   assign err_a[2] = i32.err;
   assign word_a[0] = 32'(i4.out_word);
   assign word_a[1] = 32'(i8.out_word);
   assign word_a[2] = i32.out_word;
   assign idx_a[0] = i4.out_idx;
   assign idx_a[1] = i8.out_idx;
   assign idx_a[2] = i32.out_idx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_idle(input int n, input string tag);
      chk({tag, "_valid"}, 32'(valid_a[n]), 0);
      chk({tag, "_busy"}, 32'(busy_a[n]), 0);
      chk({tag, "_done"}, 32'(done_a[n]), 0);
      chk({tag, "_last"}, 32'(last_a[n]), 0);
   endtask

   task automatic err_chk(input int n, input int k);
      @(negedge clk);
      start_a[n] = 1'b1;
      weight_a[n] = 6'(k);
      @(negedge clk);
      start_a[n] = 1'b0;
      chk("err_pulse", 32'(err_a[n]), 1);
      chk_idle(n, "err1");
      @(negedge clk);
      chk("err_clear", 32'(err_a[n]), 0);
      chk_idle(n, "err2");
   endtask

   // Model: positions of the k ones, stepped through k-subsets in colex (= ascending numeric) order
   task automatic run(input int n, input int k, input int pct, input int re_idx, input int rst_idx);
      int w, p[32], cnt, cyc, j;
      longint tot;
      logic [31:0] m, pw, pi;
      logic fin, stl;
      w = n == 0 ? 4 : n == 1 ? 8 : 32;
      tot = 1;
      for (int i = 0; i < k; i++) tot = tot * (w - i) / (i + 1);
      for (int i = 0; i < k; i++) p[i] = i;
      cnt = 0; cyc = 0; fin = 1'b0; stl = 1'b0; pw = 0; pi = 0;
      @(negedge clk);
      start_a[n] = 1'b1;
      weight_a[n] = 6'(k);
      rdy_a[n] = 1'b0;
      @(negedge clk);
      chk("latency", 32'(valid_a[n]), 1);
      while (!fin && cyc < 5000) begin
         cyc++;
         start_a[n] = 1'b0;
         rdy_a[n] = $urandom_range(99) < pct;
         m = 0;
         for (int i = 0; i < k; i++) m = m | (32'd1 << p[i]);
         if (stl) begin
            chk("hold_word", word_a[n], pw);
            chk("hold_idx", idx_a[n], pi);
         end
         chk("valid", 32'(valid_a[n]), 1);
         chk("word", word_a[n], m);
         chk("idx", idx_a[n], 32'(cnt));
         chk("last", 32'(last_a[n]), 32'(longint'(cnt) == tot - 1));
         chk("popcount", 32'($countones(word_a[n])), 32'(k));
         if (cnt > 0 && !stl) chk("ascending", 32'(word_a[n] > pw), 1);
         if (cnt == re_idx && !stl) begin
            start_a[n] = 1'b1;
            weight_a[n] = 6'd5;
         end
         if (cnt == rst_idx) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_word", word_a[n], 0);
            chk("rst_idx", idx_a[n], 0);
            chk_idle(n, "rst");
            start_a[n] = 1'b0;
            rdy_a[n] = 1'b0;
            repeat (2) begin
               @(negedge clk);
               chk("rst_done", 32'(done_a[n]), 0);
            end
            rst_n = 1'b1;
            repeat (2) begin
               @(negedge clk);
               chk_idle(n, "post_rst");
            end
            return;
         end
         pw = word_a[n];
         pi = idx_a[n];
         stl = !rdy_a[n];
         if (rdy_a[n]) begin
            if (longint'(cnt) == tot - 1) fin = 1'b1;
            else begin
               j = 0;
               while (j < k - 1 && p[j] + 1 == p[j + 1]) j++;
               p[j]++;
               for (int i = 0; i < j; i++) p[i] = i;
            end
            cnt++;
         end
         @(negedge clk);
      end
      if (!fin) chk("timeout", 0, 1);
      start_a[n] = 1'b0;
      rdy_a[n] = 1'b0;
      chk("count", 32'(cnt), 32'(tot));
      chk("end_valid", 32'(valid_a[n]), 0);
      chk("done_pulse", 32'(done_a[n]), 1);
      chk("busy_in_done", 32'(busy_a[n]), 1);
      @(negedge clk);
      chk_idle(n, "after_done");
   endtask

   initial begin
      for (int n = 0; n < 3; n++) begin
         start_a[n] = 1'b0;
         weight_a[n] = '0;
         rdy_a[n] = 1'b0;
      end
      #12;
      for (int n = 0; n < 3; n++) begin
         chk_idle(n, "reset");
         chk("reset_word", word_a[n], 0);
         chk("reset_idx", idx_a[n], 0);
         chk("reset_err", 32'(err_a[n]), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 2, 100, -1, -1);
      run(2, 1, 100, -1, -1);
      run(2, 0, 100, -1, -1);
      run(2, 32, 100, -1, -1);
      err_chk(2, 33);
      err_chk(0, 5);
      run(1, 3, 50, -1, -1);
      run(0, 4, 40, -1, -1);
      run(2, 16, 100, 10, 100);
      run(2, 2, 100, -1, -1);
      run(1, 8, 70, -1, -1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
